// File: rtl/tdc_hit_encoder.sv
// TDC hit encoder: captures thermometer-coded TOA/TOT per hit, converts to binary
// with bubble flags, and buffers the packed word in a small show-ahead FIFO.
module tdc_hit_encoder #(
    parameter int TOA_FINE_W = 63,
    parameter int TOT_FINE_W = 31,
    parameter int DEPTH      = 4,
    localparam int TOA_BIN_W = $clog2(TOA_FINE_W + 1),
    localparam int TOT_BIN_W = $clog2(TOT_FINE_W + 1),
    localparam int WORD_W    = 2 + 3 + TOA_BIN_W + 3 + TOT_BIN_W,
    localparam int PTR_W     = $clog2(DEPTH),
    localparam int LVL_W     = PTR_W + 1
) (
    input  logic                  clk40,
    input  logic                  reset,
    input  logic                  enable,
    input  logic                  hit_valid,
    input  logic [TOA_FINE_W-1:0] toa_raw,
    input  logic [2:0]            toa_coarse,
    input  logic [TOT_FINE_W-1:0] tot_raw,
    input  logic [2:0]            tot_coarse,
    output logic [WORD_W-1:0]     dout,
    output logic                  dout_valid,
    input  logic                  rd_en,
    output logic [LVL_W-1:0]      fifo_level,
    output logic [7:0]            overflow_cnt
);

    // Read handshake: a word transfers on an edge where dout_valid && rd_en.
    // dout holds the head entry until popped; rd_en with dout_valid low is ignored.

    logic                  s1_valid;
    logic [TOA_FINE_W-1:0] s1_toa_raw;
    logic [2:0]            s1_toa_coarse;
    logic [TOT_FINE_W-1:0] s1_tot_raw;
    logic [2:0]            s1_tot_coarse;

    always_ff @(posedge clk40) begin
        if (reset) begin
            s1_valid      <= 1'b0;
            s1_toa_raw    <= '0;
            s1_toa_coarse <= '0;
            s1_tot_raw    <= '0;
            s1_tot_coarse <= '0;
        end else begin
            s1_valid <= enable && hit_valid;
            if (enable && hit_valid) begin
                s1_toa_raw    <= toa_raw;
                s1_toa_coarse <= toa_coarse;
                s1_tot_raw    <= tot_raw;
                s1_tot_coarse <= tot_coarse;
            end
        end
    end

    // Population count tolerates bubbles; the flag still reports them.
    logic [TOA_BIN_W-1:0] toa_fine;
    logic [TOT_BIN_W-1:0] tot_fine;
    logic                 toa_bubble;
    logic                 tot_bubble;

    always_comb begin
        toa_fine = '0;
        for (int i = 0; i < TOA_FINE_W; i++) begin
            toa_fine = toa_fine + TOA_BIN_W'(s1_toa_raw[i]);
        end
        tot_fine = '0;
        for (int i = 0; i < TOT_FINE_W; i++) begin
            tot_fine = tot_fine + TOT_BIN_W'(s1_tot_raw[i]);
        end
    end

    assign toa_bubble = |(s1_toa_raw[TOA_FINE_W-1:1] & ~s1_toa_raw[TOA_FINE_W-2:0]);
    assign tot_bubble = |(s1_tot_raw[TOT_FINE_W-1:1] & ~s1_tot_raw[TOT_FINE_W-2:0]);

    logic              s2_valid;
    logic [WORD_W-1:0] s2_word;

    always_ff @(posedge clk40) begin
        if (reset) begin
            s2_valid <= 1'b0;
            s2_word  <= '0;
        end else begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                s2_word <= {toa_bubble, tot_bubble, s1_toa_coarse, toa_fine,
                            s1_tot_coarse, tot_fine};
            end
        end
    end

    logic [WORD_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [LVL_W-1:0]  level;
    logic              full;
    logic              empty;
    logic              push;
    logic              pop;
    logic              drop;

    assign empty = (level == '0);
    assign full  = (level == LVL_W'(DEPTH));
    assign pop   = rd_en && !empty;
    // A full FIFO still accepts a word when the same edge frees a slot.
    assign push  = s2_valid && (!full || pop);
    assign drop  = s2_valid && full && !pop;

    always_ff @(posedge clk40) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            level        <= '0;
            overflow_cnt <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= s2_word;
                wr_ptr      <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   level <= level + LVL_W'(1);
                2'b01:   level <= level - LVL_W'(1);
                default: level <= level;
            endcase
            if (drop && overflow_cnt != 8'hFF) begin
                overflow_cnt <= overflow_cnt + 8'd1;
            end
        end
    end

    assign dout_valid = !empty;
    assign dout       = empty ? '0 : mem[rd_ptr];
    assign fifo_level = level;

endmodule

// File: tb/tb_tdc_hit_encoder.sv
// Directed bench for tdc_hit_encoder: expected words go into a queue at stimulus
// time and a negedge monitor checks every popped word against it.
module tb_tdc_hit_encoder;

    logic        clk40 = 1'b0;
    logic        reset;
    logic        enable;
    logic        hit_valid;
    logic [62:0] toa_raw;
    logic [2:0]  toa_coarse;
    logic [30:0] tot_raw;
    logic [2:0]  tot_coarse;
    logic [18:0] dout;
    logic        dout_valid;
    logic        rd_en;
    logic [2:0]  fifo_level;
    logic [7:0]  overflow_cnt;

    logic [18:0] exp_q[$];
    int n_vec = 0;
    int n_err = 0;

    tdc_hit_encoder #(.TOA_FINE_W(63), .TOT_FINE_W(31), .DEPTH(4)) dut (
        .clk40(clk40), .reset(reset), .enable(enable), .hit_valid(hit_valid),
        .toa_raw(toa_raw), .toa_coarse(toa_coarse), .tot_raw(tot_raw),
        .tot_coarse(tot_coarse), .dout(dout), .dout_valid(dout_valid),
        .rd_en(rd_en), .fifo_level(fifo_level), .overflow_cnt(overflow_cnt)
    );

    // clock/reset block
    always #5 clk40 = ~clk40;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [62:0] therm63(input int n);
        logic [62:0] t = '0;
        for (int j = 0; j < n; j++) t[j] = 1'b1;
        return t;
    endfunction

    function automatic logic [30:0] therm31(input int n);
        logic [30:0] t = '0;
        for (int j = 0; j < n; j++) t[j] = 1'b1;
        return t;
    endfunction

    // Bubble-free thermometer word: fine code equals the number of ones.
    function automatic logic [18:0] pk(input int n, input int c1, input int m, input int c2);
        return {2'b00, 3'(c1), 6'(n), 3'(c2), 5'(m)};
    endfunction

    // scoreboard monitor
    always @(negedge clk40) begin
        if (!reset && rd_en && dout_valid) begin
            if (exp_q.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL pop_unexpected: got %0h expected none", dout);
            end else begin
                check("pop_data", {13'd0, dout}, {13'd0, exp_q.pop_front()});
            end
        end
    end

    // driver tasks
    task automatic tick();
        @(posedge clk40);
        #1;
    endtask

    task automatic hit_cycle(input int n, input int c1, input int m, input int c2, input bit store);
        toa_raw    = therm63(n);
        toa_coarse = 3'(c1);
        tot_raw    = therm31(m);
        tot_coarse = 3'(c2);
        hit_valid  = 1'b1;
        if (store) exp_q.push_back(pk(n, c1, m, c2));
        tick();
        hit_valid = 1'b0;
    endtask

    task automatic bulk_hit(input int i, input bit store);
        hit_cycle((i * 5) % 64, i % 8, (i * 3) % 32, (i + 1) % 8, store);
    endtask

    task automatic drain();
        int k = 0;
        rd_en = 1'b1;
        while (dout_valid && k < 20) begin
            tick();
            k++;
        end
        rd_en = 1'b0;
        check("drain_bound", {31'd0, dout_valid}, 32'd0);
    endtask

    initial begin
        reset = 1'b1; enable = 1'b1; hit_valid = 1'b0; rd_en = 1'b0;
        toa_raw = '0; toa_coarse = '0; tot_raw = '0; tot_coarse = '0;
        tick();
        tick();
        check("rst_valid", {31'd0, dout_valid}, 32'd0);
        check("rst_level", {29'd0, fifo_level}, 32'd0);
        check("rst_ovf", {24'd0, overflow_cnt}, 32'd0);
        check("rst_dout", {13'd0, dout}, 32'd0);
        reset = 1'b0;

        // basic encode, 3-cycle latency
        hit_cycle(20, 3, 7, 1, 1'b1);
        tick();
        check("lat_not_yet", {31'd0, dout_valid}, 32'd0);
        tick();
        check("basic_valid", {31'd0, dout_valid}, 32'd1);
        check("basic_dout", {13'd0, dout}, 32'h0D427);
        check("basic_level", {29'd0, fifo_level}, 32'd1);
        drain();

        // bubble in TOA code
        toa_raw = 63'h0000_0000_0000_00F7; toa_coarse = 3'd0;
        tot_raw = '0; tot_coarse = 3'd0; hit_valid = 1'b1;
        exp_q.push_back(19'h40700);
        tick();
        hit_valid = 1'b0;
        tick();
        tick();
        check("bubble_dout", {13'd0, dout}, 32'h40700);

        // all-ones codes, then zero codes
        hit_cycle(63, 7, 31, 7, 1'b1);
        hit_cycle(0, 5, 0, 2, 1'b1);
        tick();
        tick();
        check("extremes_level", {29'd0, fifo_level}, 32'd3);
        drain();

        // enable low: strobes ignored
        enable = 1'b0;
        hit_cycle(10, 1, 10, 1, 1'b0);
        enable = 1'b1;
        tick(); tick(); tick();
        check("enable_low", {31'd0, dout_valid}, 32'd0);

        // full / overflow: 6 back-to-back, only first 4 kept
        for (int i = 1; i <= 6; i++) bulk_hit(i, i <= 4);
        tick(); tick(); tick();
        check("full_level", {29'd0, fifo_level}, 32'd4);
        check("full_ovf", {24'd0, overflow_cnt}, 32'd2);

        // full plus simultaneous read: pops line up with arriving pushes
        for (int k = 0; k < 6; k++) begin
            if (k < 4) begin
                toa_raw = therm63(((k + 7) * 5) % 64); toa_coarse = 3'((k + 7) % 8);
                tot_raw = therm31(((k + 7) * 3) % 32); tot_coarse = 3'((k + 8) % 8);
                hit_valid = 1'b1;
                exp_q.push_back(pk(((k + 7) * 5) % 64, (k + 7) % 8, ((k + 7) * 3) % 32, (k + 8) % 8));
            end else begin
                hit_valid = 1'b0;
            end
            rd_en = (k >= 2);
            tick();
            if (k >= 2) check("fullrd_level", {29'd0, fifo_level}, 32'd4);
        end
        hit_valid = 1'b0;
        rd_en = 1'b0;
        tick();
        check("fullrd_ovf", {24'd0, overflow_cnt}, 32'd2);
        drain();

        // saturation: 4 kept, 300 dropped
        for (int i = 0; i < 304; i++) bulk_hit(i + 20, i < 4);
        tick(); tick(); tick();
        check("sat_ovf", {24'd0, overflow_cnt}, 32'd255);
        check("sat_level", {29'd0, fifo_level}, 32'd4);
        drain();

        // rd_en while empty
        rd_en = 1'b1;
        tick();
        tick();
        rd_en = 1'b0;
        check("empty_rd_level", {29'd0, fifo_level}, 32'd0);
        check("empty_rd_dout", {13'd0, dout}, 32'd0);

        // push into empty with rd_en held high
        rd_en = 1'b1;
        hit_cycle(33, 6, 12, 4, 1'b1);
        tick();
        tick();
        check("push_empty_valid", {31'd0, dout_valid}, 32'd1);
        check("push_empty_level", {29'd0, fifo_level}, 32'd1);
        tick();
        rd_en = 1'b0;
        check("push_empty_popped", {29'd0, fifo_level}, 32'd0);

        // reset mid-operation with 3 stored and 2 in flight
        for (int i = 0; i < 3; i++) bulk_hit(i + 40, 1'b1);
        tick(); tick(); tick();
        check("pre_rst_level", {29'd0, fifo_level}, 32'd3);
        bulk_hit(50, 1'b0);
        bulk_hit(51, 1'b0);
        reset = 1'b1;
        tick();
        exp_q.delete();
        reset = 1'b0;
        check("midrst_valid", {31'd0, dout_valid}, 32'd0);
        check("midrst_level", {29'd0, fifo_level}, 32'd0);
        check("midrst_ovf", {24'd0, overflow_cnt}, 32'd0);
        begin
            logic seen = 1'b0;
            for (int k = 0; k < 6; k++) begin
                tick();
                if (dout_valid) seen = 1'b1;
            end
            check("midrst_no_ghost", {31'd0, seen}, 32'd0);
        end

        check("queue_empty", exp_q.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/tdc_hit_encoder.md
# tdc_hit_encoder

Encodes and buffers per-hit TDC data on the clk40 domain, directly downstream of the TDC controller. It accepts the latched TOA/TOT delay-line thermometer codes and coarse counts once per hit, converts the thermometer codes to binary, flags bubbles, and packs TOA and TOT into one word. The word goes into a small show-ahead FIFO that readout logic drains through a valid/read handshake.

## Interface
- TOA_FINE_W, 63: TOA thermometer width; binary fine code is 6 bits.
- TOT_FINE_W, 31: TOT thermometer width; binary fine code is 5 bits.
- DEPTH, 4: FIFO entries, power of two, 2..16.
- clk40  in  1  single block clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- enable  in  1  high: hits accepted; low: hit_valid ignored, pipeline and FIFO still operate.
- hit_valid  in  1  one-cycle strobe: raw inputs valid this cycle.
- toa_raw  in  TOA_FINE_W  TOA thermometer code, bit 0 = first delay cell.
- toa_coarse  in  3  TOA coarse count.
- tot_raw  in  TOT_FINE_W  TOT thermometer code.
- tot_coarse  in  3  TOT coarse count.
- dout  out  19  {toa_bubble, tot_bubble, toa_code[8:0], tot_code[7:0]}, head of FIFO.
- dout_valid  out  1  FIFO not empty.
- rd_en  in  1  pop head when dout_valid.
- fifo_level  out  clog2(DEPTH)+1  current occupancy.
- overflow_cnt  out  8  dropped hits, saturating.

## Operation
- Stage 1 (capture): on an edge with enable && hit_valid, register toa_raw, toa_coarse, tot_raw, tot_coarse; set s1_valid. Otherwise s1_valid = 0 and the data registers hold.
- Stage 2 (encode): fine = population count of the thermometer code. This is bubble-tolerant. TOA fine ranges 0..63 and TOT fine 0..31. Bubble flag = 1 if any i has raw[i]=0 and raw[i+1]=1. toa_code = {toa_coarse, toa_fine}; tot_code = {tot_coarse, tot_fine}. Register the result with s2_valid.
- FIFO write: s2_valid pushes the stage-2 word.
  - When full and rd_en is low: drop the word and increment overflow_cnt, which saturates at 255.
  - When full and rd_en is high in the same cycle: pop and push both occur, nothing is dropped, and the level is unchanged.
- FIFO read: show-ahead. dout always shows the head entry. An edge with rd_en && dout_valid pops the entry. rd_en while empty is ignored, with no underflow and no pointer change.
- Level and pointers:
  - Push only: level +1. Pop only: level -1. Both: unchanged.
  - Read and write pointers wrap modulo DEPTH.
- Reset: on any edge with reset high, clear s1_valid, s2_valid, FIFO pointers, fifo_level and overflow_cnt. Hits already in flight are lost. Reset overrides hit_valid and rd_en on the same edge.

## Timing
- Reset values: dout_valid=0, fifo_level=0, overflow_cnt=0, dout=0. The FIFO storage is also cleared, so dout reads 0 while empty.
- Latency:
  - hit_valid sampled at edge E0, stage 1 at E0, stage 2 at E1.
  - The FIFO write occurs at E2, so dout_valid rises after E2.
  - Total: 3 cycles from hit strobe to visible data.
- Throughput: one hit per cycle sustained, on back-to-back hit_valid.
- Read-to-next-word: the pop at edge R means the next entry appears on dout after R, with zero bubble cycles.
- Pushing into an empty FIFO while rd_en is high: rd_en is ignored on that edge (empty), and the word becomes visible after that edge.
- overflow_cnt updates on the same edge as the dropped write.
- enable deasserted mid-stream: hits already in stages 1 and 2 complete normally.

## Test plan
- Basic encode:
  - Stimulus: reset 2 cycles, then one hit with toa_raw = 2^20-1 (20 ones), toa_coarse=3, tot_raw = 2^7-1, tot_coarse=1.
  - Required: dout_valid after 3 cycles; dout = {0,0,9'h0D4,8'h27}; fifo_level=1.
- Bubble:
  - Stimulus: toa_raw = 63'h0000_0000_0000_00F7 (7 ones), tot_raw=0, coarse=0.
  - Required: toa_fine=7, toa_bubble=1, tot_bubble=0, tot_code=0.
- Full/overflow:
  - Stimulus: DEPTH=4, rd_en=0, 6 back-to-back hits.
  - Required: fifo_level=4, overflow_cnt=2, and the FIFO holds hits 1-4 in order.
- Full plus simultaneous read:
  - Stimulus: with the FIFO full, hold rd_en=1 during 4 further back-to-back hits.
  - Required: no overflow increment, level stays 4, output order preserved.
- Saturation and empty read:
  - Stimulus: force 300 drops; also pulse rd_en while empty.
  - Required: overflow_cnt=255; rd_en while empty leaves level 0 and pointers unchanged.
- Reset mid-operation:
  - Stimulus: with 3 entries stored and hits in flight, assert reset for 1 cycle.
  - Required: next cycle dout_valid=0, level=0, overflow_cnt=0, and no in-flight hit appears afterwards.
